// File: rtl/l1_dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate L1 data-cache controller with
// one word per line, a single-request bus port and snoop invalidation.
module l1_dcache_ctrl #(
    parameter int unsigned LINES = 16,
    parameter int unsigned n     = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         core_req,
    input  logic         core_we,
    input  logic [n-1:0] core_addr,
    input  logic [n-1:0] core_wdata,
    input  logic [3:0]   core_be,
    output logic [n-1:0] core_rdata,
    output logic         L1_busy,
    output logic         bus_req,
    output logic         bus_we,
    output logic [n-1:0] bus_addr,
    output logic [n-1:0] bus_wdata,
    output logic [3:0]   bus_be,
    input  logic         bus_ack,
    input  logic [n-1:0] bus_rdata,
    input  logic         snoop_inv,
    input  logic [n-1:0] snoop_addr
);

    localparam int unsigned IDX = $clog2(LINES);
    localparam int unsigned TW  = n - IDX - 2;

    typedef enum logic [1:0] {StIdle, StBus, StDone} state_e;

    state_e state_q, state_d;

    logic [LINES-1:0] valid_q;
    logic [TW-1:0]    tag_mem  [LINES];
    logic [n-1:0]     data_mem [LINES];

    logic [IDX-1:0] idx_q;
    logic [TW-1:0]  tag_q;
    logic [n-1:0]   wdata_q;
    logic [n-1:0]   fill_q;
    logic [3:0]     be_q;
    logic           we_q;

    logic [IDX-1:0] idx, sidx;
    logic [TW-1:0]  tag, stag;
    logic           hit, snoop_hit, fill, store_hit, snoop_clr, start;
    logic           unused_addr_bits;

    assign idx  = core_addr[IDX+1:2];
    assign tag  = core_addr[n-1:IDX+2];
    assign sidx = snoop_addr[IDX+1:2];
    assign stag = snoop_addr[n-1:IDX+2];
    assign unused_addr_bits = ^{core_addr[1:0], snoop_addr[1:0]};

    assign hit       = valid_q[idx] && (tag_mem[idx] == tag);
    assign snoop_hit = valid_q[sidx] && (tag_mem[sidx] == stag);
    assign start     = (state_q == StIdle) && core_req && (core_we || !hit);
    assign fill      = reset && (state_q == StBus) && bus_ack && !we_q;
    assign store_hit = reset && (state_q == StBus) && bus_ack && we_q &&
                       valid_q[idx_q] && (tag_mem[idx_q] == tag_q);
    // A line being refilled this cycle is judged against its new tag, not the old one.
    assign snoop_clr = snoop_inv && ((fill && (sidx == idx_q)) ? (stag == tag_q) : snoop_hit);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            valid_q <= '0;
            idx_q   <= '0;
            tag_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                idx_q   <= idx;
                tag_q   <= tag;
                wdata_q <= core_wdata;
                be_q    <= core_be;
                we_q    <= core_we;
            end
            if (fill) begin
                valid_q[idx_q] <= 1'b1;
                fill_q         <= bus_rdata;
            end
            if (snoop_clr) valid_q[sidx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[idx_q]  <= tag_q;
            data_mem[idx_q] <= bus_rdata;
        end else if (store_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) data_mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StBus;
            StBus:   if (bus_ack) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        core_rdata = '0;
        L1_busy    = 1'b0;
        bus_req    = 1'b0;
        bus_we     = 1'b0;
        bus_addr   = '0;
        bus_wdata  = '0;
        bus_be     = 4'h0;
        if (reset) begin
            unique case (state_q)
                StIdle: begin
                    if (core_req) begin
                        if (!core_we && hit) core_rdata = data_mem[idx];
                        else                 L1_busy    = 1'b1;
                    end
                end
                StBus: begin
                    L1_busy   = 1'b1;
                    bus_req   = 1'b1;
                    bus_we    = we_q;
                    bus_addr  = {tag_q, idx_q, 2'b00};
                    bus_wdata = we_q ? wdata_q : '0;
                    bus_be    = we_q ? be_q : 4'hF;
                end
                StDone: begin
                    if (!we_q) core_rdata = fill_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_l1_dcache_ctrl.sv
// Directed bench for l1_dcache_ctrl: a small bus responder plus a queue of
// expected load results popped when each access retires.
module tb_l1_dcache_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req, core_we;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic [3:0]  core_be;
    logic        L1_busy;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        snoop_inv;
    logic [31:0] snoop_addr;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    l1_dcache_ctrl #(.LINES(16), .n(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_be    (core_be),
        .core_rdata (core_rdata),
        .L1_busy    (L1_busy),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_be     (bus_be),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata),
        .snoop_inv  (snoop_inv),
        .snoop_addr (snoop_addr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // snp: 0 none, 1 snoop own address in the bus_ack cycle, 2 snoop with the request
    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int dly, input logic [31:0] brdata,
                          input bit exp_bus, input logic [31:0] exp_rd, input int snp,
                          input string tag);
        int          stall = 0;
        int          bus_wait = 0;
        bit          seen = 1'b0;
        bit          done = 1'b0;
        logic [31:0] s_addr = '0, s_wdata = '0, got_rd = '0, want;
        logic [3:0]  s_be = '0;
        logic        s_we = 1'b0;
        @(posedge clk); #1;
        core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata; core_be = be;
        if (snp == 2) begin snoop_inv = 1'b1; snoop_addr = addr; end
        exp_q.push_back(exp_rd);
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            @(negedge clk);
            bus_ack = 1'b0;
            if (snp == 1) snoop_inv = 1'b0;
            if (!L1_busy) begin
                done   = 1'b1;
                got_rd = core_rdata;
                check({tag, " bus_req at retire"}, {31'b0, bus_req}, 32'd0);
            end else begin
                stall++;
                if (bus_req) begin
                    bus_wait++;
                    if (!seen) begin
                        s_addr = bus_addr; s_wdata = bus_wdata; s_be = bus_be; s_we = bus_we;
                    end else begin
                        check({tag, " bus_addr stable"}, bus_addr, s_addr);
                    end
                    seen = 1'b1;
                    if (bus_wait > dly) begin
                        bus_ack = 1'b1; bus_rdata = brdata;
                        if (snp == 1) begin snoop_inv = 1'b1; snoop_addr = addr; end
                    end
                end
            end
        end
        @(posedge clk); #1;
        core_req = 1'b0; snoop_inv = 1'b0; bus_ack = 1'b0;
        want = exp_q.pop_front();
        check({tag, " retired"}, {31'b0, done}, 32'd1);
        check({tag, " rdata"}, got_rd, want);
        check({tag, " stall"}, stall, exp_bus ? dly + 2 : 0);
        check({tag, " bus used"}, {31'b0, seen}, {31'b0, exp_bus});
        if (exp_bus && seen) begin
            check({tag, " bus_addr"}, s_addr, addr & 32'hFFFF_FFFC);
            check({tag, " bus_we"}, {31'b0, s_we}, {31'b0, we});
            check({tag, " bus_be"}, {28'b0, s_be}, {28'b0, (we ? be : 4'hF)});
            if (we) check({tag, " bus_wdata"}, s_wdata, wdata);
        end
    endtask

    task automatic snoop(input logic [31:0] addr);
        @(posedge clk); #1;
        snoop_inv = 1'b1; snoop_addr = addr;
        @(posedge clk); #1;
        snoop_inv = 1'b0;
    endtask

    initial begin
        reset = 1'b0; core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        core_be = '0; bus_ack = 1'b0; bus_rdata = '0; snoop_inv = 1'b0; snoop_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset L1_busy", {31'b0, L1_busy}, 32'd0);
        check("reset bus_req", {31'b0, bus_req}, 32'd0);
        check("reset core_rdata", core_rdata, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        access(0, 32'h100, 0, 4'h0, 3, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, "miss 100");
        access(0, 32'h100, 0, 4'h0, 0, 32'h0, 0, 32'hDEADBEEF, 0, "hit 100");
        access(1, 32'h100, 32'h0000CAFE, 4'b0011, 0, 32'h0, 1, 32'h0, 0, "store hit 100");
        access(0, 32'h100, 0, 4'h0, 0, 32'h0, 0, 32'hDEADCAFE, 0, "merged 100");
        access(1, 32'h200, 32'h0BB0_0BB0, 4'hF, 1, 32'h0, 1, 32'h0, 0, "store miss 200");
        access(0, 32'h200, 0, 4'h0, 0, 32'h12345678, 1, 32'h12345678, 0, "no alloc 200");
        access(0, 32'h107, 0, 4'h0, 2, 32'h0000_0104, 1, 32'h0000_0104, 0, "miss 107");
        access(0, 32'h104, 0, 4'h0, 0, 32'h0, 0, 32'h0000_0104, 0, "hit 104");
        access(0, 32'h100, 0, 4'h0, 0, 32'hA5A50100, 1, 32'hA5A50100, 0, "replace 100");
        snoop(32'h140);
        access(0, 32'h100, 0, 4'h0, 0, 32'h0, 0, 32'hA5A50100, 0, "snoop other tag");
        snoop(32'h100);
        access(0, 32'h100, 0, 4'h0, 0, 32'h0BADF00D, 1, 32'h0BADF00D, 1, "snoop on fill");
        access(0, 32'h100, 0, 4'h0, 0, 32'h11112222, 1, 32'h11112222, 0, "after fill snoop");
        access(0, 32'h100, 0, 4'h0, 0, 32'h0, 0, 32'h11112222, 2, "hit with snoop");
        access(0, 32'h100, 0, 4'h0, 0, 32'h33334444, 1, 32'h33334444, 0, "after hit snoop");
        access(1, 32'h100, 32'h55556666, 4'hF, 0, 32'h0, 1, 32'h0, 1, "store snoop ack");
        access(0, 32'h100, 0, 4'h0, 0, 32'h77778888, 1, 32'h77778888, 0, "after store snoop");
        access(0, 32'h104, 0, 4'h0, 0, 32'h0, 0, 32'h0000_0104, 0, "hit 104 again");

        // Reset in the middle of a bus transaction, then a stale ack.
        @(posedge clk); #1;
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h300;
        @(negedge clk);
        @(negedge clk);
        check("mid reset in BUS", {31'b0, bus_req}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0; core_req = 1'b0;
        @(negedge clk);
        check("reset low L1_busy", {31'b0, L1_busy}, 32'd0);
        check("reset low core_rdata", core_rdata, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("after reset bus_req", {31'b0, bus_req}, 32'd0);
        check("after reset bus_addr", bus_addr, 32'd0);
        bus_ack = 1'b1; bus_rdata = 32'hFFFF0000;
        @(negedge clk);
        bus_ack = 1'b0;
        check("late ack bus_req", {31'b0, bus_req}, 32'd0);
        check("late ack L1_busy", {31'b0, L1_busy}, 32'd0);
        access(0, 32'h104, 0, 4'h0, 0, 32'h9999AAAA, 1, 32'h9999AAAA, 0, "post reset 104");
        access(0, 32'h100, 0, 4'h0, 1, 32'hCCCCDDDD, 1, 32'hCCCCDDDD, 0, "post reset 100");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/l1_dcache_ctrl.md
# l1_dcache_ctrl

Per-core L1 data-cache controller sitting directly downstream of the RISC-V core's load/store path. It produces the core's `L1_busy` stall. Direct-mapped, one 32-bit word per line, write-through with no write-allocate, Valid/Invalid coherence. Misses and all stores go over a single-request shared-bus handshake. Lines are invalidated by snooped remote writes, keeping the coherence logic minimal in area.

## Interface
- `LINES`, 16: number of lines, power of two ≥ 2; `IDX = log2(LINES)`.
- `n`, 32: data and address width.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `core_req` in 1: core presents a load or store this cycle.
- `core_we` in 1: 1 = store.
- `core_addr` in n: byte address; `[1:0]` ignored.
- `core_wdata` in n: store data.
- `core_be` in 4: store byte enables; ignored for loads.
- `core_rdata` out n: load data.
- `L1_busy` out 1: stall; the core holds every `core_*` input stable while this is high.
- `bus_req` out 1: bus request.
- `bus_we` out 1: bus write.
- `bus_addr` out n: word-aligned bus address.
- `bus_wdata` out n: bus write data.
- `bus_be` out 4: bus byte enables.
- `bus_ack` in 1: one-cycle completion strobe.
- `bus_rdata` in n: read data, valid with `bus_ack`.
- `snoop_inv` in 1: another agent wrote `snoop_addr` this cycle.
- `snoop_addr` in n: snooped byte address.

## Operation
- Address split: `index = addr[IDX+1:2]`, `tag = addr[n-1:IDX+2]`.
- Per line: `valid` flop with reset; tag and data arrays without reset.
- `hit = valid[index] && tag[index]==tag(core_addr)`.
- FSM states:
  - **IDLE**
    - Load hit: `core_rdata` = line data (combinational), `L1_busy` = 0, no bus activity.
    - Load miss or any store: `L1_busy` = 1 combinationally; latch address, wdata, be, we; go to BUS.
  - **BUS**
    - Drive `bus_req`=1 with `bus_we`, `bus_addr`={addr[n-1:2],2'b00}, `bus_wdata`, and `bus_be` (4'hF on reads), all held stable until `bus_ack`. `L1_busy` = 1.
    - On `bus_ack` for a read: write tag and data, set valid, capture `bus_rdata` into the fill register.
    - On `bus_ack` for a store: if the line hits, merge `core_wdata` into the line per `core_be`; on a miss the line is untouched.
    - Next state: DONE.
  - **DONE**
    - `L1_busy` = 0; `core_rdata` = fill register on loads.
    - The core retires the access at this clock edge. Next state: IDLE unconditionally; no new lookup is accepted in DONE.
- `core_rdata` = 0 whenever the controller is neither returning a hit nor in DONE.
- Snoop: if `snoop_inv` is set and `snoop_addr` hits a valid line, clear `valid` at the clock edge. This applies in every state.
- Simultaneous events:
  - Snoop on the line being filled in the `bus_ack` cycle: the line ends invalid, but the fill data is still returned to the core.
  - Snoop on the line of a same-cycle load hit: the load returns the old data; the line is invalid afterwards.
  - Snoop on the line of an own store hit, on the `bus_ack` edge: invalidation wins.

## Timing
- Load hit: 0 stall cycles.
- Miss or store, with `bus_ack` asserted in the first BUS cycle: IDLE (busy) → BUS (busy) → DONE, i.e. 2 stall cycles. Each extra bus wait cycle adds 1 stall cycle.
- `bus_req` rises in the first BUS cycle and falls the cycle after `bus_ack`.
- Reset low (sampled at the clock edge), including mid-transaction:
  - All `valid` cleared; state → IDLE.
  - `bus_req`, `bus_we`, `bus_addr`, `bus_wdata`, `bus_be` = 0.
  - `L1_busy` = 0 and `core_rdata` = 0 while reset is low.
  - A `bus_ack` arriving after reset is ignored.
- Any address with a matching index but different tag is a miss. On a fill, the old line is silently replaced; write-through means no victim writeback.

## Test plan
- After reset, load 0x100 with ack 3 cycles after `bus_req`, `bus_rdata`=0xDEADBEEF → `L1_busy` high 5 cycles, DONE returns 0xDEADBEEF; an immediate reload of 0x100 hits with 0 stall and `bus_req` stays 0.
- Store 0x100, `core_be`=4'b0011, data 0x0000CAFE, on a cached line → one bus write with `bus_be`=0011; the following load of 0x100 hits and returns 0xDEADCAFE.
- Store 0x200 on a miss → bus write issued; the following load of 0x200 misses, proving no write-allocate.
- Fill 0x100, then `snoop_inv` with `snoop_addr`=0x100 → the next load of 0x100 misses. A snoop to 0x140 (same index for LINES=16, different tag) has no effect.
- Load miss on 0x100 with `snoop_inv`=0x100 in the `bus_ack` cycle → core gets the fill data; the next load of 0x100 misses.
- Reset pulled low while in BUS, then a late `bus_ack` → `bus_req` drops the next edge; all lines invalid; the late ack is ignored.
